lcd_timing_gen: RTL
===================

# lcd_timing_gen

Display timing generator for the 800x480 camera preview path. It runs the horizontal and vertical counters and issues a one-cycle-ahead pixel request to the frame-buffer read FIFO. It publishes the active-area X/Y coordinates that the overlay stage consumes, and re-times the returned RGB into a panel-ready stream with DE, HS and VS.

## Interface
- H_ACTIVE, 800, visible pixels per line
- H_FRONT, 210, front-porch clocks
- H_SYNC, 1, HS low width
- H_BACK, 45, back-porch clocks
- V_ACTIVE, 480, visible lines
- V_FRONT, 22, front-porch lines
- V_SYNC, 1, VS low width (lines)
- V_BACK, 22, back-porch lines
- COLOR_W, 12, bits per colour channel
- iCLK  in  1  pixel clock; all logic on rising edge
- iRST_N  in  1  asynchronous active-low reset
- iRed / iGreen / iBlue  in  COLOR_W each  pixel data, valid the cycle after oRequest
- iPAT_EN  in  1  test-pattern select (see Configuration)
- oRequest  out  1  FIFO read strobe
- oX_Cont  out  11  active-area column, 0..H_ACTIVE-1
- oY_Cont  out  11  active-area row, 0..V_ACTIVE-1
- oLCD_R / oLCD_G / oLCD_B  out  COLOR_W each  panel colour
- oLCD_DE  out  1  data enable
- oLCD_HS / oLCD_VS  out  1  active-low syncs
- oFrameStart  out  1  one-cycle pulse, aligned with oRequest, at pixel (0,0)

## Operation
- The line is H_TOTAL = H_SYNC+H_BACK+H_ACTIVE+H_FRONT clocks (1056). The frame is V_TOTAL lines (525).
- h_cnt runs 0..H_TOTAL-1 and wraps to 0. v_cnt increments when h_cnt wraps, running 0..V_TOTAL-1 and wrapping to 0.
- Region order, on both axes: sync [0,SYNC), back porch, active [SYNC+BACK, SYNC+BACK+ACTIVE), front porch.
- Active is h_act AND v_act.
- X = h_cnt-(H_SYNC+H_BACK) and Y = v_cnt-(V_SYNC+V_BACK) during active. Both are forced to 0 outside active.
- Blanking colour is 0 on all channels.
- Counter widths are 11 bits. All arithmetic is unsigned, with no overflow inside the legal ranges.

## Timing
- Cycle t: counters hold position P.
- Cycle t+1: oRequest, oX_Cont, oY_Cont and oFrameStart reflect P.
- Cycle t+2: iRed/iGreen/iBlue carry the data for P.
- Cycle t+3: oLCD_R/G/B, oLCD_DE, oLCD_HS and oLCD_VS reflect P.
- Sync outputs are delayed by 3 cycles so they stay aligned with DE.
- oRequest is high exactly H_ACTIVE cycles per active line and 0 on blank lines. This gives 384000 requests per frame, never more.
- Reset values: h_cnt=v_cnt=0, oRequest=0, oX/oY=0, RGB=0, DE=0, HS=VS=1, oFrameStart=0. The pipeline is cleared.
- After reset deassertion the counters start at (0,0). The first oFrameStart arrives at cycle H_TOTAL*(V_SYNC+V_BACK)+H_SYNC+H_BACK+1.
- Reset mid-frame aborts the frame immediately. No partial request burst continues. The FIFO owner must flush on the same reset.

## Configuration
- TEST_PATTERN_EN defined: when iPAT_EN=1 at stage t+3, the output is replaced by eight vertical bars, each 100 columns wide (X from stage t+1, piped).
  - Bar order: white, yellow, cyan, green, magenta, red, blue, black.
  - Each channel is all-ones or 0.
  - oRequest is unaffected, so the FIFO keeps draining.
- TEST_PATTERN_EN undefined: iPAT_EN is ignored and no pattern logic exists.

## Structure
- Shared package holds:
  - the default timing constants (800x480 set);
  - H_TOTAL and V_TOTAL derivations;
  - the 11-bit coordinate typedef;
  - the bar-colour table.
- Sub-module lcd_axis_counter is instantiated twice (H and V). It takes params SYNC/BACK/ACTIVE/FRONT, an enable and a wrap output, and provides the region flags and offset position.

## Test plan
- Reset release, run 2 frames -> exactly 384000 oRequest pulses per frame; oFrameStart period exactly 554400 clocks.
- Line check -> oLCD_HS low for 1 clock per 1056; oLCD_DE high for 800 contiguous clocks starting 46 clocks after the HS falling edge.
- Feed iRed = low bits of a sample counter incremented on each oRequest -> oLCD_R on the first DE cycle of a line equals the value returned for oX_Cont=0; the value on the last DE cycle matches oX_Cont=799.
- Coordinates -> oX_Cont 0..799 and oY_Cont 0..479 during requests, 0 elsewhere; oY_Cont increments once per active line.
- Assert iRST_N low at line 200, column 400, for 5 clocks -> all outputs at reset values asynchronously; after release the counters restart at (0,0).
- TEST_PATTERN_EN with iPAT_EN=1 -> column 150 output is yellow (R=G=0xFFF, B=0); column 799 output is 0.

Source files
------------

// File: rtl/lcd_timing_gen_pkg.sv
// Shared 800x480 panel timing constants, coordinate type and colour-bar table.
// The TEST_PATTERN_EN build uses the bar table and bar_rgb().
package lcd_timing_gen_pkg;

    localparam int H_ACTIVE = 800;
    localparam int H_FRONT  = 210;
    localparam int H_SYNC   = 1;
    localparam int H_BACK   = 45;
    localparam int V_ACTIVE = 480;
    localparam int V_FRONT  = 22;
    localparam int V_SYNC   = 1;
    localparam int V_BACK   = 22;
    localparam int COLOR_W  = 12;

    localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

    localparam int COORD_W = 11;
    typedef logic [COORD_W-1:0] coord_t;

    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
    } ctl_t;

    localparam ctl_t CTL_IDLE = '{de: 1'b0, hs: 1'b1, vs: 1'b1};

    // Entry 0 is the leftmost bar; each entry is {r,g,b}.
    localparam int BAR_W = 100;
    localparam logic [7:0][2:0] BAR_RGB = {
        3'b000, 3'b001, 3'b100, 3'b101,
        3'b010, 3'b011, 3'b110, 3'b111
    };

    function automatic logic [2:0] bar_rgb(input coord_t x);
        return BAR_RGB[3'(x / coord_t'(BAR_W))];
    endfunction

endpackage

// File: rtl/lcd_axis_counter.sv
// One display axis: free-running position counter with region flags and
// the offset position inside the active window.
module lcd_axis_counter
    import lcd_timing_gen_pkg::*;
#(
    parameter int SYNC   = 1,
    parameter int BACK   = 45,
    parameter int ACTIVE = 800,
    parameter int FRONT  = 210
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   en,
    output logic   wrap,
    output logic   sync,
    output logic   act,
    output coord_t pos
);

    localparam int     TOTAL = SYNC + BACK + ACTIVE + FRONT;
    localparam coord_t LAST  = coord_t'(TOTAL - 1);
    localparam coord_t S_END = coord_t'(SYNC);
    localparam coord_t A_BEG = coord_t'(SYNC + BACK);
    localparam coord_t A_END = coord_t'(SYNC + BACK + ACTIVE);

    coord_t cnt_d, cnt_q;

    assign wrap = en && (cnt_q == LAST);
    assign sync = cnt_q < S_END;
    assign act  = (cnt_q >= A_BEG) && (cnt_q < A_END);
    assign pos  = act ? cnt_q - A_BEG : '0;

    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/lcd_timing_gen.sv
// 800x480 LCD timing generator: FIFO request, X/Y, re-timed RGB/DE/HS/VS.
// Define TEST_PATTERN_EN to build the iPAT_EN colour-bar override.
module lcd_timing_gen
    import lcd_timing_gen_pkg::*;
(
    input  logic               iCLK,
    input  logic               iRST_N,
    input  logic [COLOR_W-1:0] iRed,
    input  logic [COLOR_W-1:0] iGreen,
    input  logic [COLOR_W-1:0] iBlue,
    input  logic               iPAT_EN,
    output logic               oRequest,
    output coord_t             oX_Cont,
    output coord_t             oY_Cont,
    output logic [COLOR_W-1:0] oLCD_R,
    output logic [COLOR_W-1:0] oLCD_G,
    output logic [COLOR_W-1:0] oLCD_B,
    output logic               oLCD_DE,
    output logic               oLCD_HS,
    output logic               oLCD_VS,
    output logic               oFrameStart
);

    logic   h_wrap, h_sync, h_act;
    logic   v_wrap, v_sync, v_act;
    logic   act;
    coord_t h_pos, v_pos;

    lcd_axis_counter #(
        .SYNC(H_SYNC), .BACK(H_BACK), .ACTIVE(H_ACTIVE), .FRONT(H_FRONT)
    ) u_h (
        .clk(iCLK), .rst_n(iRST_N), .en(1'b1),
        .wrap(h_wrap), .sync(h_sync), .act(h_act), .pos(h_pos)
    );

    lcd_axis_counter #(
        .SYNC(V_SYNC), .BACK(V_BACK), .ACTIVE(V_ACTIVE), .FRONT(V_FRONT)
    ) u_v (
        .clk(iCLK), .rst_n(iRST_N), .en(h_wrap),
        .wrap(v_wrap), .sync(v_sync), .act(v_act), .pos(v_pos)
    );

    assign act = h_act && v_act;

    ctl_t   s1_d, s1_q, s2_d, s2_q, s3_d, s3_q;
    coord_t x_d, x_q, y_d, y_q;
    logic   fs_d, fs_q, arm_d, arm_q;
    logic [COLOR_W-1:0] r_d, r_q, g_d, g_q, b_d, b_q;
`ifdef TEST_PATTERN_EN
    coord_t     x2_d, x2_q;
    logic [2:0] bar;
    assign bar = bar_rgb(x2_q);
`endif

    always_comb begin
        s1_d  = '{de: act, hs: !h_sync, vs: !v_sync};
        x_d   = act ? h_pos : '0;
        y_d   = act ? v_pos : '0;
        // Armed at frame end, fires on the first active pixel (0,0).
        fs_d  = act && arm_q;
        arm_d = v_wrap ? 1'b1 : (act ? 1'b0 : arm_q);
        s2_d  = s1_q;
        s3_d  = s2_q;
        r_d   = '0;
        g_d   = '0;
        b_d   = '0;
        if (s2_q.de) begin
            r_d = iRed;
            g_d = iGreen;
            b_d = iBlue;
        end
`ifdef TEST_PATTERN_EN
        x2_d = x_q;
        if (s2_q.de && iPAT_EN) begin
            r_d = {COLOR_W{bar[2]}};
            g_d = {COLOR_W{bar[1]}};
            b_d = {COLOR_W{bar[0]}};
        end
`endif
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            s1_q  <= CTL_IDLE;
            s2_q  <= CTL_IDLE;
            s3_q  <= CTL_IDLE;
            x_q   <= '0;
            y_q   <= '0;
            fs_q  <= 1'b0;
            arm_q <= 1'b1;
            r_q   <= '0;
            g_q   <= '0;
            b_q   <= '0;
`ifdef TEST_PATTERN_EN
            x2_q  <= '0;
`endif
        end else begin
            s1_q  <= s1_d;
            s2_q  <= s2_d;
            s3_q  <= s3_d;
            x_q   <= x_d;
            y_q   <= y_d;
            fs_q  <= fs_d;
            arm_q <= arm_d;
            r_q   <= r_d;
            g_q   <= g_d;
            b_q   <= b_d;
`ifdef TEST_PATTERN_EN
            x2_q  <= x2_d;
`endif
        end
    end

    assign oRequest    = s1_q.de;
    assign oX_Cont     = x_q;
    assign oY_Cont     = y_q;
    assign oFrameStart = fs_q;
    assign oLCD_DE     = s3_q.de;
    assign oLCD_HS     = s3_q.hs;
    assign oLCD_VS     = s3_q.vs;
    assign oLCD_R      = r_q;
    assign oLCD_G      = g_q;
    assign oLCD_B      = b_q;

endmodule
